mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported unified memory between instruction fetch (IF) and data memory access (DM) in the multi-cycle-memory version of the processor.
- Grants one requester at a time and issues a one-cycle command to memory. It then waits for memory completion and returns data with a one-cycle done pulse.
- Generates the global stall that freezes the pipeline while a requester waits.
- Policy: DM priority, starvation guard for IF, fetch flush/halt handling, memory timeout error.

Parameters:
- STARVE_MAX, 4: consecutive DM grants allowed while IF is waiting; the next grant is forced to IF.
- TIMEOUT, 32: cycles allowed in a busy state without mem_done before an error abort.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- if_req  in  1  fetch request; level, held until if_done or if_flush
- if_addr  in  16  fetch address (PC)
- if_flush  in  1  discard the pending/in-flight fetch (taken branch/jump)
- halt  in  1  processor halted; no new IF grants
- dm_en  in  1  data request; level, held until dm_done
- dm_wr  in  1  1 = store, 0 = load
- dm_addr  in  16  data address (ALU result)
- dm_wdata  in  16  store data (reg2 data)
- mem_en  out  1  memory command strobe
- mem_wr  out  1  memory write enable, valid with mem_en
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_done  in  1  memory completion, one cycle
- if_data  out  16  fetched instruction
- if_done  out  1  fetch complete pulse
- dm_rdata  out  16  load data
- dm_done  out  1  data access complete pulse
- stall  out  1  pipeline freeze
- err  out  1  sticky timeout error

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0; timeout counter 0.
- All outputs are registered.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE grant rules, evaluated each cycle:
  - IF is eligible when if_req=1, if_flush=0, halt=0.
  - If the starvation counter equals STARVE_MAX and IF is eligible, grant IF.
  - Otherwise, if dm_en=1, grant DM.
  - Otherwise, if IF is eligible, grant IF.
  - Otherwise stay in IDLE.
- On a grant, the next cycle drives mem_en=1 for exactly one cycle, with mem_addr and mem_wr/mem_wdata captured from the granted requester (mem_wr=0 for IF). State moves to BUSY_x.
- mem_addr and mem_wdata hold their values until the next command.
- Starvation counter:
  - Increments on each DM grant made while if_req=1 and if_flush=0.
  - Clears on an IF grant or whenever if_req=0.
  - Saturates at STARVE_MAX.
- BUSY_x: wait for mem_done. mem_done is ignored in the cycle mem_en is high; it is legal from the following cycle on.
- On mem_done in BUSY_DM: dm_rdata <= mem_rdata (loads only; stores leave dm_rdata unchanged), dm_done=1 for one cycle, state to IDLE.
- On mem_done in BUSY_IF: if_data <= mem_rdata and if_done=1 for one cycle, unless a flush occurred. State to IDLE.
- Flush:
  - if_flush=1 at any point during BUSY_IF sets an internal discard flag.
  - The access still completes; if_done stays 0 and if_data is unchanged.
  - The flag clears on leaving BUSY_IF.
- New grants are considered in the cycle after return to IDLE. Minimum request-to-done latency is 3 cycles: grant, issue, done.
- stall = 1 when, in any state, (dm_en=1 and no dm_done this cycle) or (if_req=1, if_flush=0, halt=0, and no if_done this cycle). Combinational from inputs plus the registered done outputs.
- Timeout:
  - The counter increments each cycle in BUSY_x and clears on entering BUSY.
  - When it reaches TIMEOUT without mem_done: err <= 1 (sticky until rst), no done pulse, state to IDLE.
- Simultaneous events:
  - mem_done together with if_flush in BUSY_IF means the fetch is discarded.
  - halt asserted mid-BUSY_IF does not abort the fetch; it completes normally.
  - dm_en and if_req rising together in IDLE gives DM the grant unless the starvation counter forces IF.
- rst mid-operation returns everything to reset values immediately. A late mem_done arriving after reset, in IDLE, is ignored.

Test Plan:
- Fetch only, if_addr=0x0010, mem_done 2 cycles after mem_en with mem_rdata=0xA5C3 -> mem_en one cycle with mem_addr=0x0010 and mem_wr=0; if_done pulses with if_data=0xA5C3; stall high until the if_done cycle.
- Store, dm_en=1, dm_wr=1, dm_addr=0x0100, dm_wdata=0x1234, with if_req=1 simultaneously -> DM granted first with mem_wr=1 and mem_wdata=0x1234; dm_done pulses; IF granted next.
- Back-to-back loads with if_req held, STARVE_MAX=4 -> 4 DM grants, 5th grant goes to IF, then DM resumes.
- if_flush pulsed during BUSY_IF, mem_rdata=0xFFFF -> no if_done and if_data unchanged; a new fetch at the new address is granted afterward.
- Memory never asserts mem_done -> err=1 after 32 busy cycles, state IDLE, no done pulse; err holds until rst.
- halt=1 with if_req=1 -> no mem_en issued, stall=0; rst asserted mid-BUSY_DM -> outputs 0 immediately and a subsequent mem_done is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-ported unified memory between fetch (IF) and data access (DM): DM priority, IF starvation guard, flush discard, timeout error.
// Grant -> one-cycle mem_en -> wait for mem_done -> registered done pulse; stall freezes the pipeline while either requester waits.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  input  logic        halt,
  input  logic        dm_en,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] if_data,
  output logic        if_done,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [SW-1:0] starveCnt;
  logic [TW-1:0] toCnt;
  logic          discard;
  logic          settle;
  logic          curWr;
  logic          ifElig;
  logic          grantIf;
  logic          grantDm;
  logic          memAck;
  logic          timedOut;

  // settle blocks a grant in the first IDLE cycle, while the finished requester still holds its request.
  always_comb begin
    ifElig  = if_req && !if_flush && !halt;
    grantIf = 1'b0;
    grantDm = 1'b0;
    if (state == IDLE && !settle) begin
      if (starveCnt == SW'(STARVE_MAX) && ifElig) begin
        grantIf = 1'b1;
      end else if (dm_en) begin
        grantDm = 1'b1;
      end else if (ifElig) begin
        grantIf = 1'b1;
      end
    end
  end

  // A completion in the command cycle itself cannot belong to this access.
  assign memAck   = mem_done && !mem_en;
  assign timedOut = !memAck && (toCnt == TW'(TIMEOUT - 1));
  assign stall    = (dm_en && !dm_done) || (ifElig && !if_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= '0;
      toCnt     <= '0;
      discard   <= 1'b0;
      settle    <= 1'b0;
      curWr     <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_data   <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_wr  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      settle  <= 1'b0;

      if (!if_req || grantIf) begin
        starveCnt <= '0;
      end else if (grantDm && !if_flush && starveCnt != SW'(STARVE_MAX)) begin
        starveCnt <= starveCnt + SW'(1);
      end

      case (state)
        IDLE: begin
          if (grantDm) begin
            state     <= BUSY_DM;
            mem_en    <= 1'b1;
            mem_wr    <= dm_wr;
            curWr     <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            toCnt     <= '0;
          end else if (grantIf) begin
            state    <= BUSY_IF;
            mem_en   <= 1'b1;
            curWr    <= 1'b0;
            mem_addr <= if_addr;
            toCnt    <= '0;
          end
        end

        BUSY_IF, BUSY_DM: begin
          toCnt <= toCnt + TW'(1);
          if (state == BUSY_IF && if_flush) begin
            discard <= 1'b1;
          end
          if (memAck) begin
            if (state == BUSY_DM) begin
              dm_done <= 1'b1;
              if (!curWr) begin
                dm_rdata <= mem_rdata;
              end
            end else if (!discard && !if_flush) begin
              if_done <= 1'b1;
              if_data <= mem_rdata;
            end
          end else if (timedOut) begin
            err <= 1'b1;
          end
          if (memAck || timedOut) begin
            state   <= IDLE;
            discard <= 1'b0;
            settle  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) mem_en |=> !mem_en);
  assert property (@(posedge clk) disable iff (rst) !(if_done && dm_done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory responder plus command/completion scoreboards.
module tb_mem_arbiter;

  logic        clk, rst, if_req, if_flush, halt, dm_en, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        mem_en, mem_wr, if_done, dm_done, stall, err;
  logic [15:0] mem_addr, mem_wdata, if_data, dm_rdata;

  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] wdata; } cmd_t;
  typedef struct packed { logic isDm; logic isStore; logic [15:0] data; } done_t;

  cmd_t        cmdQ[$];
  done_t       doneQ[$];
  cmd_t        mc;
  done_t       md;
  logic [15:0] shadowIf, shadowDm, respAddr;
  int          nVec = 0;
  int          nErr = 0;
  int          memLat = 2;
  bit          memMute = 0;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .halt(halt),
    .dm_en(dm_en), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_data(if_data), .if_done(if_done), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents as seen by the bench; 0x0030 reads as all ones.
  function automatic logic [15:0] memVal(input logic [15:0] a);
    return (a == 16'h0030) ? 16'hFFFF : (a ^ 16'hA5D3);
  endfunction

  task automatic expCmd(input logic wr, input logic [15:0] a, input logic [15:0] d);
    cmdQ.push_back('{wr, a, d});
  endtask

  task automatic expDone(input logic isDm, input logic isStore, input logic [15:0] d);
    doneQ.push_back('{isDm, isStore, d});
  endtask

  // Memory responder: completes each command memLat cycles after mem_en.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_en && !memMute) begin
        respAddr = mem_addr;
        repeat (memLat) @(negedge clk);
        mem_done  = 1'b1;
        mem_rdata = memVal(respAddr);
        @(negedge clk);
        mem_done  = 1'b0;
        mem_rdata = 16'h0;
      end
    end
  end

  // Command and completion monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (cmdQ.size() == 0) begin
          checkVal("unexpCmd", 16'(mem_en), 16'd0);
        end else begin
          mc = cmdQ.pop_front();
          checkVal("cmdAddr", mem_addr, mc.addr);
          checkVal("cmdWr", 16'(mem_wr), 16'(mc.wr));
          if (mc.wr) checkVal("cmdWdata", mem_wdata, mc.wdata);
        end
      end
      if (if_done || dm_done) begin
        if (doneQ.size() == 0) begin
          checkVal("unexpDone", {14'd0, if_done, dm_done}, 16'd0);
        end else begin
          md = doneQ.pop_front();
          checkVal("doneKind", {14'd0, if_done, dm_done}, md.isDm ? 16'd1 : 16'd2);
          if (md.isDm) begin
            checkVal("dmRdata", dm_rdata, md.isStore ? shadowDm : md.data);
            if (!md.isStore) shadowDm = md.data;
          end else begin
            checkVal("ifData", if_data, md.data);
            shadowIf = md.data;
          end
        end
      end
    end
  end

  task automatic waitMemEn();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_en && n < 50);
    if (!mem_en) checkVal("memEnWait", 16'(mem_en), 16'd1);
  endtask

  task automatic waitIfDone();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 200);
    if (!if_done) checkVal("ifWait", 16'(if_done), 16'd1);
  endtask

  task automatic ifReq(input logic [15:0] a);
    if_req  = 1'b1;
    if_addr = a;
    waitIfDone();
    if_req  = 1'b0;
  endtask

  task automatic dmReq(input logic wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    dm_en = 1'b1; dm_wr = wr; dm_addr = a; dm_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_done && n < 200);
    if (!dm_done) checkVal("dmWait", 16'(dm_done), 16'd1);
    dm_en = 1'b0;
  endtask

  task automatic checkResetOuts();
    checkVal("rstMemEn", 16'(mem_en), 16'd0);
    checkVal("rstMemWr", 16'(mem_wr), 16'd0);
    checkVal("rstMemAddr", mem_addr, 16'd0);
    checkVal("rstMemWdata", mem_wdata, 16'd0);
    checkVal("rstIfData", if_data, 16'd0);
    checkVal("rstIfDone", 16'(if_done), 16'd0);
    checkVal("rstDmRdata", dm_rdata, 16'd0);
    checkVal("rstDmDone", 16'(dm_done), 16'd0);
    checkVal("rstStall", 16'(stall), 16'd0);
    checkVal("rstErr", 16'(err), 16'd0);
  endtask

  initial begin : mainSeq
    int n;
    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0; halt = 0;
    dm_en = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
    shadowIf = 16'h0; shadowDm = 16'h0;
    repeat (3) @(negedge clk);
    checkResetOuts();
    rst = 1'b0;
    @(negedge clk);

    // Fetch only: stall holds until the done cycle, done four cycles after the request.
    expCmd(1'b0, 16'h0010, 16'h0); expDone(1'b0, 1'b0, 16'hA5C3);
    if_req = 1'b1; if_addr = 16'h0010; n = 0;
    do begin
      @(negedge clk); n++;
      if (!if_done) checkVal("stallWait", 16'(stall), 16'd1);
    end while (!if_done && n < 50);
    checkVal("fetchLat", 16'(n), 16'd4);
    checkVal("stallAtDone", 16'(stall), 16'd0);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Starvation guard: four DM loads, then IF, then DM resumes.
    for (int i = 0; i < 4; i++) begin
      expCmd(1'b0, 16'h0400 + 16'(i), 16'h0); expDone(1'b1, 1'b0, memVal(16'h0400 + 16'(i)));
    end
    expCmd(1'b0, 16'h0050, 16'h0); expDone(1'b0, 1'b0, memVal(16'h0050));
    expCmd(1'b0, 16'h0404, 16'h0); expDone(1'b1, 1'b0, memVal(16'h0404));
    fork
      begin
        for (int i = 0; i < 5; i++) dmReq(1'b0, 16'h0400 + 16'(i), 16'h0);
      end
      ifReq(16'h0050);
    join
    repeat (2) @(negedge clk);

    // Store racing a fetch: DM first, store leaves dm_rdata untouched, IF next.
    expCmd(1'b1, 16'h0100, 16'h1234); expDone(1'b1, 1'b1, 16'h0);
    expCmd(1'b0, 16'h0020, 16'h0);    expDone(1'b0, 1'b0, memVal(16'h0020));
    fork
      dmReq(1'b1, 16'h0100, 16'h1234);
      ifReq(16'h0020);
    join
    repeat (2) @(negedge clk);

    // Flush mid-fetch: all-ones read discarded, refetch at the new address.
    expCmd(1'b0, 16'h0030, 16'h0); expCmd(1'b0, 16'h0040, 16'h0);
    expDone(1'b0, 1'b0, memVal(16'h0040));
    if_req = 1'b1; if_addr = 16'h0030;
    waitMemEn();
    @(negedge clk); if_flush = 1'b1; if_addr = 16'h0040;
    #1 checkVal("stallFlush", 16'(stall), 16'd0);
    @(negedge clk); if_flush = 1'b0;
    @(negedge clk);
    checkVal("flushData", if_data, shadowIf);
    checkVal("flushNoDone", 16'(if_done), 16'd0);
    waitIfDone();
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Flush in the same cycle as mem_done: discarded.
    expCmd(1'b0, 16'h0060, 16'h0);
    if_req = 1'b1; if_addr = 16'h0060;
    waitMemEn();
    @(negedge clk);
    @(negedge clk); if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk); if_flush = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("flushSimData", if_data, shadowIf);

    // Halt blocks IF grants and stall; halt raised mid-fetch does not abort.
    halt = 1'b1; if_req = 1'b1; if_addr = 16'h0080;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("haltMemEn", 16'(mem_en), 16'd0);
      checkVal("haltStall", 16'(stall), 16'd0);
    end
    expCmd(1'b0, 16'h0080, 16'h0); expDone(1'b0, 1'b0, memVal(16'h0080));
    halt = 1'b0;
    waitMemEn();
    halt = 1'b1;
    waitIfDone();
    if_req = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: memory silent, err after 32 busy cycles, no done, sticky.
    memMute = 1'b1;
    expCmd(1'b0, 16'h0200, 16'h0);
    dm_en = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
    waitMemEn();
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 60);
    checkVal("toCycles", 16'(n), 16'd32);
    checkVal("toNoDone", 16'(dm_done), 16'd0);
    dm_en = 1'b0;
    memMute = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("errSticky", 16'(err), 16'd1);
    expCmd(1'b0, 16'h0070, 16'h0); expDone(1'b0, 1'b0, memVal(16'h0070));
    ifReq(16'h0070);
    checkVal("errStillSet", 16'(err), 16'd1);
    repeat (2) @(negedge clk);

    // Reset mid-BUSY_DM; the late mem_done lands in IDLE and is ignored.
    memLat = 4;
    expCmd(1'b0, 16'h0300, 16'h0);
    dm_en = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
    waitMemEn();
    @(negedge clk);
    rst = 1'b1; dm_en = 1'b0;
    shadowIf = 16'h0; shadowDm = 16'h0;
    #1 checkResetOuts();
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    checkVal("lateDmRdata", dm_rdata, 16'd0);
    checkVal("lateDmDone", 16'(dm_done), 16'd0);
    memLat = 2;

    checkVal("cmdLeft", 16'(cmdQ.size()), 16'd0);
    checkVal("doneLeft", 16'(doneQ.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nVec);
    $fatal(1);
  end

endmodule
